// File: rtl/aemb2_pkg.sv
// Shared encodings for the AEMB2 data/FSL bus controller: access sizes, FSM states,
// byte-lane constants and the lane-select decode.
package aemb2_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_FSL  = 2'd3;

    localparam logic [3:0] SEL_FSL  = 4'h0;
    localparam logic [3:0] SEL_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBUS = 2'd1,
        FBUS = 2'd2
    } dwbState_t;

    // Big-endian lanes: lane 3 carries byte address 0.
    function automatic logic [3:0] laneSel(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: laneSel = 4'h8 >> a;
            SZ_HALF: laneSel = a[1] ? 4'h3 : 4'hC;
            SZ_WORD: laneSel = SEL_WORD;
            default: laneSel = SEL_FSL;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] a);
        isMisaligned = ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/aemb2_bus_wdt.sv
// Bus-cycle wait counter: cleared when a cycle is launched, flags expiry on the TOUT-th
// strobe cycle without an acknowledge.
module aemb2_bus_wdt
    import aemb2_pkg::*;
#(
    parameter int TOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TOUT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)   cnt <= 16'd0;
        else if (clr) cnt <= 16'd0;
        else if (run) cnt <= cnt + 16'd1;
    end

    assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/aemb2_dwb_ctl.sv
// Data-bus / FSL bus-cycle controller: one bus cycle per load/store/get/put, pipeline stall
// until acknowledge. Optional ack timeout with AEMB2_DWB_TIMEOUT_EN.
module aemb2_dwb_ctl
    import aemb2_pkg::*;
#(
    parameter int TOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ena_i,
    input  logic        req_i,
    input  logic        wre_i,
    input  logic [5:0]  rOPC_OF,
    input  logic [31:0] rADR_OF,
    output logic [29:0] dwb_adr_o,
    output logic [3:0]  dwb_sel_o,
    output logic        dwb_stb_o,
    output logic        dwb_wre_o,
    input  logic        dwb_ack_i,
    output logic        cwb_stb_o,
    output logic        cwb_wre_o,
    input  logic        cwb_ack_i,
    output logic [3:0]  rSEL_MA,
    output logic        ena_o,
    output logic        err_o,
    output dwbState_t   dbgState
);

    // Handshake: stb rises the cycle after a request is accepted and stays high with
    // adr/sel/wre frozen until a rising edge samples the matching ack; stb then drops.
    dwbState_t  state, stateNext;
    logic [1:0] sz;
    logic       accept, misalign, busAck, abort, errNext;
    logic       unusedOpc;

    assign sz        = rOPC_OF[1:0];
    assign unusedOpc = ^rOPC_OF[5:2];
    assign accept    = (state == IDLE) && ena_i && req_i;
    assign misalign  = isMisaligned(sz, rADR_OF[1:0]);
    assign busAck    = ((state == DBUS) && dwb_ack_i) || ((state == FBUS) && cwb_ack_i);
    assign dbgState  = state;

`ifdef AEMB2_DWB_TIMEOUT_EN
    logic expired;

    aemb2_bus_wdt #(.TOUT(TOUT)) uWdt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (accept),
        .run     (state != IDLE),
        .expired (expired)
    );

    // An ack on the expiry cycle completes the access normally.
    assign abort = expired && !busAck;
`else
    logic unusedTout;
    assign unusedTout = ^TOUT;
    assign abort      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        errNext   = 1'b0;
        dwb_stb_o = (state == DBUS);
        cwb_stb_o = (state == FBUS);
        ena_o     = (state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misalign)          errNext   = 1'b1;
                    else if (sz == SZ_FSL) stateNext = FBUS;
                    else                   stateNext = DBUS;
                end
            end
            DBUS, FBUS: begin
                errNext = abort;
                if (busAck || abort) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // rSEL_MA only changes on an accepted request so the resizer stays valid through MA.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dwb_adr_o <= 30'd0;
            dwb_sel_o <= 4'd0;
            dwb_wre_o <= 1'b0;
            cwb_wre_o <= 1'b0;
            rSEL_MA   <= 4'd0;
            err_o     <= 1'b0;
        end else begin
            err_o <= errNext;
            if (accept) begin
                if (misalign) begin
                    rSEL_MA <= SEL_WORD;
                end else begin
                    dwb_adr_o <= rADR_OF[31:2];
                    dwb_sel_o <= laneSel(sz, rADR_OF[1:0]);
                    rSEL_MA   <= laneSel(sz, rADR_OF[1:0]);
                    dwb_wre_o <= wre_i && (sz != SZ_FSL);
                    cwb_wre_o <= wre_i && (sz == SZ_FSL);
                end
            end
        end
    end

endmodule
